// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus for pc_fetch_unit.
// master: imem_req, imem_addr out; imem_data, imem_ack in. slave: mirror.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output imem_ack
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register with inc/branch/absolute update, plus req/ack fetch into IR.
// Ports: clock, reset (async active-low), PS, PCSEL, EN_PC, IL, br_off,
//   reg_data, imem (pc_fetch_unit_if.master), PC, pc_plus4, IR, ir_valid,
//   fetch_busy, fetch_err. Optional macro: FETCH_TIMEOUT_EN (fetch abort).
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            PS,
    input  logic                  PCSEL,
    input  logic                  EN_PC,
    input  logic                  IL,
    input  logic [25:0]           br_off,
    input  logic [63:0]           reg_data,
    pc_fetch_unit_if.master       imem,
    output logic [63:0]           PC,
    output logic [63:0]           pc_plus4,
    output logic [31:0]           IR,
    output logic                  ir_valid,
    output logic                  fetch_busy,
    output logic                  fetch_err
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t      state, state_nx;
    logic        start, done;
    logic [63:0] pc_q, pc_nx, br_tgt_off;
    logic [63:0] addr_q;
    logic [31:0] ir_q;
    logic        valid_q;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] to_cnt;
    logic       err_q;
    logic       abort_f;
`endif

    // Byte offset already scaled by 4 (word offset << 2).
    assign br_tgt_off = PCSEL
        ? {{43{br_off[18]}}, br_off[18:0], 2'b00}
        : {{36{br_off[25]}}, br_off, 2'b00};

    always_comb begin
        pc_nx = pc_q;
        if (EN_PC) begin
            unique case (PS)
                2'b00: pc_nx = pc_q;
                2'b01: pc_nx = pc_q + 64'd4;
                2'b10: pc_nx = pc_q + br_tgt_off;
                2'b11: pc_nx = {reg_data[63:2], 2'b00};
                default: pc_nx = pc_q;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        done     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        abort_f  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (IL) begin
                    start    = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                // An ack on the timeout edge still completes the fetch.
                if (imem.imem_ack) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    abort_f  = 1'b1;
                    state_nx = IDLE;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            addr_q  <= 64'h0;
            ir_q    <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_nx;
            valid_q <= done;
            // Fetch address is the PC before any same-edge update.
            if (start) begin
                addr_q <= pc_q;
            end
            if (done) begin
                ir_q <= imem.imem_data;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= 8'h0;
            err_q  <= 1'b0;
        end else begin
            if (start) begin
                to_cnt <= 8'h0;
            end else if (state == FETCH && !imem.imem_ack) begin
                to_cnt <= to_cnt + 8'd1;
            end
            if (abort_f) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{8'(TIMEOUT_CYC), reg_data[1:0]};
    assign fetch_err  = 1'b0;
`endif

`ifdef FETCH_TIMEOUT_EN
    logic unused_bits;
    assign unused_bits = ^reg_data[1:0];
`endif

    // Request derives from state so an async reset drops it at once.
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = addr_q;
    assign fetch_busy     = (state == FETCH);
    assign PC             = pc_q;
    assign pc_plus4       = pc_q + 64'd4;
    assign IR             = ir_q;
    assign ir_valid       = valid_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-register block that responds to the control unit's PC and instruction-load control lines (PS, PCSEL, EN_PC, IL). It holds the 64-bit PC, applies increment, relative-branch and absolute-load updates, and runs a request/acknowledge fetch against instruction memory. It delivers the fetched 32-bit word as IR back to the control unit's decoder.

## Interface

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- TIMEOUT_CYC, 16, number of FETCH cycles without imem_ack before the fetch aborts (used only with FETCH_TIMEOUT_EN); legal range 1..255.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- PS  in  2  PC operation: 00 hold, 01 PC+4, 10 PC+offset, 11 absolute load.
- PCSEL  in  1  offset source for PS=10: 0 = sign-extended br_off[25:0] (B form), 1 = sign-extended br_off[18:0] (CB form).
- EN_PC  in  1  PC update enable; PS is ignored when 0.
- IL  in  1  instruction-load request.
- br_off  in  26  word offset from the instruction word.
- reg_data  in  64  absolute target for PS=11 (BR).
- imem_data  in  32  instruction memory read data, valid when imem_ack=1.
- imem_ack  in  1  instruction memory acknowledge.
- imem_req  out  1  fetch request.
- imem_addr  out  64  fetch address.
- PC  out  64  current PC register.
- pc_plus4  out  64  PC+4, combinational (link value for BL).
- IR  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse when IR has just been loaded.
- fetch_busy  out  1  high while in FETCH.
- fetch_err  out  1  sticky fetch-timeout flag.

## Operation

- Reset (reset=0, asynchronous): PC=RESET_PC, IR=0, ir_valid=0, imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, state=IDLE, timeout counter=0.
- PC update, at each edge with EN_PC=1:
  - 00: hold.
  - 01: PC+4.
  - 10: PC + (sext(off)<<2), where off is selected by PCSEL.
  - 11: {reg_data[63:2],2'b00}.
  - All arithmetic is modulo 2^64; wrap-around is silent.
- PC updates are independent of fetch state and are allowed while in FETCH.
- States:
  - IDLE: IL=1 at an edge latches imem_addr<=PC (pre-update value if EN_PC is also 1) and moves to FETCH.
  - FETCH: imem_req=1 and imem_addr is held stable. On an edge with imem_ack=1: IR<=imem_data, ir_valid=1 for the next cycle, return to IDLE.
- IL is ignored while in FETCH; requests are not queued.
- imem_ack while in IDLE is ignored.
- If IL=1 in the cycle following a completed fetch, a new fetch starts; back-to-back fetches have one IDLE cycle between them.
- IR holds its value until the next successful fetch.

## Timing

- IL sampled at edge N -> imem_req=1 from N to the edge at which imem_ack is sampled.
- Zero-wait memory (ack sampled at edge N+1) -> IR updated and ir_valid=1 after edge N+1; minimum IL-to-IR latency is 2 edges.
- ir_valid is high for exactly one cycle per successful fetch.
- PC changes one edge after EN_PC is sampled. pc_plus4 follows PC combinationally.
- Reset asserted mid-FETCH: imem_req drops immediately (asynchronously); an in-flight ack is discarded.

## Configuration

- FETCH_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYC, the fetch aborts: imem_req=0 next cycle, fetch_err<=1 (sticky until reset), IR unchanged, no ir_valid pulse, return to IDLE.
  - An ack on the same edge as the timeout wins: the fetch completes normally.
- FETCH_TIMEOUT_EN undefined: FETCH waits indefinitely, no counter is built, and fetch_err is tied to 0.

## Test plan

- Reset with RESET_PC=0; release reset, EN_PC=1 with PS=01 for 3 edges -> PC=12 and pc_plus4=16.
- PC=0x100, PS=10, PCSEL=1, br_off[18:0]=19'h7FFFF (-1) -> PC=0xFC. With PCSEL=0 and br_off=26'h0000010 -> PC=0x140.
- PS=11 with reg_data=0x1237 -> PC=0x1234. PC=64'hFFFF_FFFF_FFFF_FFFC with PS=01 -> PC=0.
- IL=1 at PC=0x40 with EN_PC=1, PS=01 in the same cycle; memory acks after 3 wait cycles with 32'h8B020020:
  - imem_addr=0x40 throughout the fetch and PC=0x44.
  - IR=32'h8B020020 with a single ir_valid pulse.
  - An IL pulse issued mid-fetch starts no second fetch.
- FETCH_TIMEOUT_EN defined, TIMEOUT_CYC=4, no ack -> imem_req drops after 4 FETCH cycles, fetch_err=1, IR unchanged. A later fetch with ack completes normally and fetch_err stays 1.
- Assert reset during FETCH -> imem_req=0 immediately and all outputs at reset values. An ack arriving after reset release causes no IR load.
